// File: rtl/rx_frame_parser_pkg.sv
// Shared frame definitions for the receive parser and the transmit frame generator:
// state encodings, error codes and CRC-16/MODBUS constants.
package rx_frame_parser_pkg;

   typedef enum logic [2:0] {
      S_ID1  = 3'd0,
      S_ID2  = 3'd1,
      S_CNT1 = 3'd2,
      S_CNT2 = 3'd3,
      S_CMD  = 3'd4,
      S_CRC1 = 3'd5,
      S_CRC2 = 3'd6
   } state_t;

   localparam logic [1:0]  ERR_TIMEOUT = 2'd0;
   localparam logic [1:0]  ERR_ID      = 2'd1;
   localparam logic [1:0]  ERR_LEN     = 2'd2;
   localparam logic [1:0]  ERR_CRC     = 2'd3;

   localparam logic [15:0] CRC_INIT  = 16'hFFFF;
   localparam logic [15:0] CRC_POLY  = 16'hA001;
   localparam logic [15:0] FRAME_CNT = 16'h0001;

   // One reflected shift of the CRC register.
   function automatic logic [15:0] crc_bit_step(input logic [15:0] c);
      crc_bit_step = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
   endfunction

endpackage

// File: rtl/rx_frame_parser_crc16.sv
// Combinational CRC-16/MODBUS update for one byte, LSB first, fully unrolled.
module crc16_byte
   import rx_frame_parser_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   logic [15:0] stage [0:8];

   always_comb begin
      stage[0] = crc_in ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         stage[i+1] = crc_bit_step(stage[i]);
      end
      crc_out = stage[8];
   end

endmodule

// File: rtl/rx_frame_parser.sv
// Byte-stream frame parser: ID1 ID2 CNT1 CNT2 CMD CRC1 CRC2, with ID/length/CRC
// checking and an inter-byte timeout; accepted commands appear on cmd/cmd_flag.
module rx_frame_parser
   import rx_frame_parser_pkg::*;
#(
   parameter logic [15:0] DEV_ID      = 16'h0000,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter bit          CRC_EN      = 1'b1
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_flag,
   output logic [7:0] cmd,
   output logic       cmd_flag,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam int          TW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   state_t        state;
   logic [15:0]   crc;
   logic [15:0]   crc_next;
   logic [TW-1:0] tcnt;
   logic [7:0]    cnt_hi;
   logic [7:0]    cmd_buf;
   logic          crc_hi_ok;

   crc16_byte u_crc (
      .crc_in  (crc),
      .data    (rx_data),
      .crc_out (crc_next)
   );

   // Frame payload capture; only meaningful while the FSM sits in the matching state.
   always_ff @(posedge sys_clk) begin
      if (rx_data_flag) begin
         case (state)
            S_CNT1:  cnt_hi    <= rx_data;
            S_CMD:   cmd_buf   <= rx_data;
            S_CRC1:  crc_hi_ok <= (rx_data == crc[15:8]);
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state     <= S_ID1;
         crc       <= CRC_INIT;
         tcnt      <= '0;
         cmd       <= 8'h00;
         cmd_flag  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= ERR_TIMEOUT;
      end else begin
         cmd_flag  <= 1'b0;
         frame_err <= 1'b0;
         if (rx_data_flag) begin
            // A byte always wins over an expiring timeout.
            tcnt <= '0;
            case (state)
               S_ID1: begin
                  if (rx_data == DEV_ID[15:8]) begin
                     state <= S_ID2;
                     crc   <= crc_next;
                  end
               end
               S_ID2: begin
                  if (rx_data == DEV_ID[7:0]) begin
                     state <= S_CNT1;
                     crc   <= crc_next;
                  end else begin
                     state     <= S_ID1;
                     crc       <= CRC_INIT;
                     frame_err <= 1'b1;
                     err_code  <= ERR_ID;
                  end
               end
               S_CNT1: begin
                  state <= S_CNT2;
                  crc   <= crc_next;
               end
               S_CNT2: begin
                  if ({cnt_hi, rx_data} == FRAME_CNT) begin
                     state <= S_CMD;
                     crc   <= crc_next;
                  end else begin
                     state     <= S_ID1;
                     crc       <= CRC_INIT;
                     frame_err <= 1'b1;
                     err_code  <= ERR_LEN;
                  end
               end
               S_CMD: begin
                  state <= S_CRC1;
                  crc   <= crc_next;
               end
               S_CRC1: state <= S_CRC2;
               S_CRC2: begin
                  if (!CRC_EN || (crc_hi_ok && rx_data == crc[7:0])) begin
                     cmd      <= cmd_buf;
                     cmd_flag <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_CRC;
                  end
                  state <= S_ID1;
                  crc   <= CRC_INIT;
               end
               default: begin
                  state <= S_ID1;
                  crc   <= CRC_INIT;
               end
            endcase
         end else if (state != S_ID1) begin
            if (tcnt == T_LAST) begin
               state     <= S_ID1;
               crc       <= CRC_INIT;
               tcnt      <= '0;
               frame_err <= 1'b1;
               err_code  <= ERR_TIMEOUT;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench: one parser with CRC checking, one with CRC bypassed, both on the
// same byte stream with DEV_ID=0 and a 16-cycle timeout.
module tb_rx_frame_parser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_flag;

   logic [7:0] cmd_a, cmd_b;
   logic       cf_a, cf_b, fe_a, fe_b;
   logic [1:0] ec_a, ec_b;

   int tests = 0;
   int fails = 0;
   int ncf_a = 0, nfe_a = 0, ncf_b = 0, nfe_b = 0, both = 0;
   int a_cf0, a_fe0, b_cf0, b_fe0;
   logic [15:0] crc_m;

   always #5 clk = ~clk;

   rx_frame_parser #(.DEV_ID(16'h0000), .TIMEOUT_CYC(16), .CRC_EN(1'b1)) dut_a (
      .sys_clk(clk), .sys_rst(rst_n), .rx_data(rx_data), .rx_data_flag(rx_flag),
      .cmd(cmd_a), .cmd_flag(cf_a), .frame_err(fe_a), .err_code(ec_a)
   );

   rx_frame_parser #(.DEV_ID(16'h0000), .TIMEOUT_CYC(16), .CRC_EN(1'b0)) dut_b (
      .sys_clk(clk), .sys_rst(rst_n), .rx_data(rx_data), .rx_data_flag(rx_flag),
      .cmd(cmd_b), .cmd_flag(cf_b), .frame_err(fe_b), .err_code(ec_b)
   );

   always @(posedge clk) begin
      if (cf_a) ncf_a <= ncf_a + 1;
      if (fe_a) nfe_a <= nfe_a + 1;
      if (cf_b) ncf_b <= ncf_b + 1;
      if (fe_b) nfe_b <= nfe_b + 1;
      if ((cf_a && fe_a) || (cf_b && fe_b)) both <= both + 1;
   end

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] x;
      x = c ^ {8'h00, b};
      for (int k = 0; k < 8; k++) begin
         if (x[0]) x = (x >> 1) ^ 16'hA001;
         else      x = x >> 1;
      end
      return x;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the next falling edge after the byte is sampled.
   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_flag = 1'b1;
      @(negedge clk);
      rx_flag = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Full frame with CRC computed by the model; x2 corrupts CRC2, gap idles after ID2.
   task automatic frame(input logic [7:0] c, input logic [7:0] x2, input int gap);
      logic [7:0] body [0:4];
      logic [15:0] crc;
      body[0] = 8'h00; body[1] = 8'h00; body[2] = 8'h00; body[3] = 8'h01; body[4] = c;
      crc = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         crc = crc_model(crc, body[k]);
         send(body[k]);
         if (k == 1 && gap > 0) idle(gap);
      end
      send(crc[15:8]);
      send(crc[7:0] ^ x2);
   endtask

   task automatic snap();
      a_cf0 = ncf_a; a_fe0 = nfe_a; b_cf0 = ncf_b; b_fe0 = nfe_b;
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_data = 8'h00;
      rx_flag = 1'b0;
      idle(3);
      check("rst_cmd",  {8'h00, cmd_a}, 16'h0000);
      check("rst_flags", {12'h000, cf_a, fe_a, cf_b, fe_b}, 16'h0000);
      check("rst_err",  {14'h0000, ec_a}, 16'h0000);
      rst_n = 1'b1;
      idle(2);

      // CRC bypass: fixed 00 00 CRC bytes are accepted only by dut_b
      crc_m = 16'hFFFF;
      crc_m = crc_model(crc_m, 8'h00); crc_m = crc_model(crc_m, 8'h00);
      crc_m = crc_model(crc_m, 8'h00); crc_m = crc_model(crc_m, 8'h01);
      crc_m = crc_model(crc_m, 8'h05);
      send(8'h00); send(8'h00); send(8'h00); send(8'h01); send(8'h05);
      send(8'h00); send(8'h00);
      check("bypass_flag", {15'h0, cf_b}, 16'h0001);
      check("bypass_cmd",  {8'h00, cmd_b}, 16'h0005);
      check("bypass_a_err", {15'h0, fe_a}, {15'h0, crc_m != 16'h0000});
      check("bypass_a_cmd", {8'h00, cmd_a}, 16'h0000);
      idle(1);
      check("flag_one_cycle", {14'h0, cf_b, fe_a}, 16'h0000);

      // Good CRC, then bad CRC2
      frame(8'hA3, 8'h00, 0);
      check("crc_ok_flag", {14'h0, cf_a, fe_a}, 16'h0002);
      check("crc_ok_cmd",  {8'h00, cmd_a}, 16'h00A3);
      idle(1);
      frame(8'hA3, 8'h01, 0);
      check("crc_bad_flags", {14'h0, cf_a, fe_a}, 16'h0001);
      check("crc_bad_code",  {14'h0, ec_a}, 16'h0003);
      check("crc_bad_cmd",   {8'h00, cmd_a}, 16'h00A3);
      check("crc_bad_b",     {15'h0, cf_b}, 16'h0001);
      idle(1);

      // ID mismatch and length error
      send(8'h00); send(8'h07);
      check("id_err",  {13'h0, fe_a, ec_a}, 16'h0005);
      check("id_err_b", {13'h0, fe_b, ec_b}, 16'h0005);
      idle(1);
      send(8'h00); send(8'h00); send(8'h00); send(8'h02);
      check("len_err", {13'h0, fe_a, ec_a}, 16'h0006);
      idle(1);

      // Timeout: 15 idle cycles are tolerated, the 16th expires
      send(8'h00); send(8'h00);
      idle(15);
      check("tmo_early", {14'h0, fe_a, fe_b}, 16'h0000);
      idle(1);
      check("tmo_err", {13'h0, fe_a, ec_a}, 16'h0004);
      check("tmo_err_b", {13'h0, fe_b, ec_b}, 16'h0004);
      idle(2);

      // Byte landing exactly on the 16th idle cycle is accepted
      snap();
      frame(8'h6C, 8'h00, 15);
      check("tmo_edge_cmd", {7'h00, cf_a, cmd_a}, 16'h016C);
      check("tmo_edge_noerr", nfe_a[15:0] - a_fe0[15:0], 16'h0000);
      idle(1);

      // Reset mid-frame discards it silently
      snap();
      send(8'h00); send(8'h00); send(8'h00);
      rst_n = 1'b0;
      idle(2);
      check("midrst_cmd", {8'h00, cmd_a}, 16'h0000);
      rst_n = 1'b1;
      idle(20);
      check("midrst_pulses", {nfe_a[3:0] - a_fe0[3:0], ncf_a[3:0] - a_cf0[3:0],
                              nfe_b[3:0] - b_fe0[3:0], ncf_b[3:0] - b_cf0[3:0]}, 16'h0000);
      frame(8'h5A, 8'h00, 0);
      check("midrst_frame", {7'h00, cf_a, cmd_a}, 16'h015A);
      idle(1);

      // Leading garbage then a valid frame
      snap();
      send(8'h7E); send(8'h7E);
      frame(8'h3C, 8'h00, 0);
      idle(1);
      check("garbage_cmd", {8'h00, cmd_a}, 16'h003C);
      check("garbage_cf",  ncf_a[15:0] - a_cf0[15:0], 16'h0001);
      check("garbage_fe",  nfe_a[15:0] - a_fe0[15:0], 16'h0000);

      // Back-to-back frames: next ID1 in the cycle right after CRC2
      snap();
      frame(8'h11, 8'h00, 0);
      check("b2b_first", {7'h00, cf_a, cmd_a}, 16'h0111);
      frame(8'h22, 8'h00, 0);
      check("b2b_second", {7'h00, cf_a, cmd_a}, 16'h0122);
      idle(1);
      check("b2b_count", {ncf_a[7:0] - a_cf0[7:0], nfe_a[7:0] - a_fe0[7:0]}, 16'h0200);

      check("no_overlap", both[15:0], 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
